cache_arbiter: RTL

Arbitrates the single physical-memory port between the L1 instruction cache and the L1 data cache. Each cache's 256-bit line-fill/write-back interface connects upstream; the arbiter drives one 256-bit burst port toward the cacheline adaptor and main memory. It serves one transaction at a time. Simultaneous requests are granted round-robin, and the granted address and data are held stable until memory responds.

---
 rtl/cache_arbiter_if.sv | 47 ++++
 rtl/cache_arbiter.sv | 109 ++++++++++
 2 files changed

// File: rtl/cache_arbiter_if.sv
// cache_arbiter_if
// Bundles the I-cache, D-cache and memory-side signals of the physical
// memory arbiter.
//   slave  : arbiter view (takes cache requests and memory responses,
//            drives cache responses and the memory request)
//   master : environment view (caches plus memory model)
interface cache_arbiter_if #(
    parameter int s_line = 256,
    parameter int s_addr = 32
);
    logic [s_addr-1:0] i_pmem_address;
    logic              i_pmem_read;
    logic [s_line-1:0] i_pmem_rdata;
    logic              i_pmem_resp;

    logic [s_addr-1:0] d_pmem_address;
    logic              d_pmem_read;
    logic              d_pmem_write;
    logic [s_line-1:0] d_pmem_wdata;
    logic [s_line-1:0] d_pmem_rdata;
    logic              d_pmem_resp;

    logic [s_addr-1:0] mem_address;
    logic              mem_read;
    logic              mem_write;
    logic [s_line-1:0] mem_wdata;
    logic [s_line-1:0] mem_rdata;
    logic              mem_resp;

    modport slave (
        input  i_pmem_address, i_pmem_read,
        input  d_pmem_address, d_pmem_read, d_pmem_write, d_pmem_wdata,
        input  mem_rdata, mem_resp,
        output i_pmem_rdata, i_pmem_resp,
        output d_pmem_rdata, d_pmem_resp,
        output mem_address, mem_read, mem_write, mem_wdata
    );

    modport master (
        output i_pmem_address, i_pmem_read,
        output d_pmem_address, d_pmem_read, d_pmem_write, d_pmem_wdata,
        output mem_rdata, mem_resp,
        input  i_pmem_rdata, i_pmem_resp,
        input  d_pmem_rdata, d_pmem_resp,
        input  mem_address, mem_read, mem_write, mem_wdata
    );
endinterface

// File: rtl/cache_arbiter.sv
// cache_arbiter
// Shares the single physical-memory burst port between the L1 I-cache and
// the L1 D-cache, one transaction at a time, round-robin on ties.
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset
//   bus  : cache_arbiter_if.slave (cache request/response + memory port)
//
// state   | meaning
// --------+----------------------------------------------------
// IDLE    | no grant, sampling requests
// GNT_I   | serving the I-cache
// GNT_D   | serving the D-cache
// RECOVER | one dead cycle so the served cache can drop its request
module cache_arbiter #(
    parameter int s_line = 256,
    parameter int s_addr = 32
) (
    input logic            clk,
    input logic            rst,
    cache_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, GNT_I, GNT_D, RECOVER} state_t;

    state_t            state;
    state_t            state_next;
    logic              last_d;
    logic [s_addr-1:0] addr_q;
    logic [s_line-1:0] wdata_q;
    logic              write_q;
    logic              i_req;
    logic              d_req;
    logic              grant_i;
    logic              grant_d;

    assign i_req = bus.i_pmem_read;
    assign d_req = bus.d_pmem_read | bus.d_pmem_write;

    // Memory side is driven only from the registers captured at grant time,
    // so upstream changes during service cannot disturb the burst.
    assign bus.mem_address  = addr_q;
    assign bus.mem_wdata    = wdata_q;
    assign bus.i_pmem_rdata = bus.mem_rdata;
    assign bus.d_pmem_rdata = bus.mem_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            last_d  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
        end else begin
            state <= state_next;
            if (grant_i) begin
                addr_q  <= bus.i_pmem_address;
                write_q <= 1'b0;
            end
            if (grant_d) begin
                addr_q  <= bus.d_pmem_address;
                wdata_q <= bus.d_pmem_wdata;
                // a simultaneous read+write from the D-cache is a write-back
                write_q <= bus.d_pmem_write;
            end
            if (state == GNT_I && bus.mem_resp) last_d <= 1'b0;
            if (state == GNT_D && bus.mem_resp) last_d <= 1'b1;
        end
    end

    always_comb begin
        state_next      = state;
        grant_i         = 1'b0;
        grant_d         = 1'b0;
        bus.mem_read    = 1'b0;
        bus.mem_write   = 1'b0;
        bus.i_pmem_resp = 1'b0;
        bus.d_pmem_resp = 1'b0;
        case (state)
            IDLE: begin
                // on a tie, the requester not served last wins
                if (i_req && (!d_req || last_d)) begin
                    grant_i    = 1'b1;
                    state_next = GNT_I;
                end else if (d_req) begin
                    grant_d    = 1'b1;
                    state_next = GNT_D;
                end
            end
            GNT_I: begin
                bus.mem_read  = ~write_q;
                bus.mem_write = write_q;
                if (bus.mem_resp) begin
                    bus.i_pmem_resp = 1'b1;
                    state_next      = RECOVER;
                end
            end
            GNT_D: begin
                bus.mem_read  = ~write_q;
                bus.mem_write = write_q;
                if (bus.mem_resp) begin
                    bus.d_pmem_resp = 1'b1;
                    state_next      = RECOVER;
                end
            end
            RECOVER: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end
endmodule
